// File: rtl/int_controller.sv
// Prioritised interrupt controller: rising-edge capture per source, lowest index wins,
// one request in flight until end-of-interrupt.
module int_controller #(
    parameter int unsigned N_SRC     = 8,
    parameter logic [15:0] VEC_BASE  = 16'h0010,
    parameter int unsigned VEC_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             cfg_write,
    input  logic [N_SRC-1:0] cfg_data,
    input  logic             mask_all,
    input  logic             unmask_all,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             cpu_interrupt,
    output logic             vec_valid,
    output logic [15:0]      vec_addr,
    output logic [3:0]       active_id,
    output logic [N_SRC-1:0] pending
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] VECTOR  = 2'd2;
    localparam logic [1:0] SERVICE = 2'd3;

    logic [1:0]       state;
    logic [N_SRC-1:0] prev_irq;
    logic [N_SRC-1:0] enable;
    logic             gie;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr_mask;
    logic             any_elig;
    logic             take_ack;
    logic [3:0]       win_id;
    logic [15:0]      win_vec;

    assign rise     = irq_src & ~prev_irq;
    assign eligible = gie ? (pending & enable) : '0;

    always_comb begin
        any_elig = 1'b0;
        win_id   = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (eligible[i] && !any_elig) begin
                any_elig = 1'b1;
                win_id   = 4'(i);
            end
        end
    end

    assign take_ack = (state == REQ) && any_elig && int_ack;
    assign clr_mask = take_ack ? (N_SRC'(1) << win_id) : '0;
    assign win_vec  = VEC_BASE + (16'(win_id) << VEC_SHIFT);

    // A fresh edge in the acknowledge cycle re-sets the bit being cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_irq <= '0;
            pending  <= '0;
            enable   <= '0;
            gie      <= 1'b0;
        end else begin
            prev_irq <= irq_src;
            pending  <= (pending & ~clr_mask) | rise;
            if (cfg_write)
                enable <= cfg_data;
            if (mask_all)
                gie <= 1'b0;
            else if (unmask_all)
                gie <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cpu_interrupt <= 1'b0;
            vec_valid     <= 1'b0;
            vec_addr      <= '0;
            active_id     <= '0;
        end else begin
            vec_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state         <= REQ;
                        cpu_interrupt <= 1'b1;
                    end
                end
                REQ: begin
                    if (!any_elig) begin
                        state         <= IDLE;
                        cpu_interrupt <= 1'b0;
                    end else if (int_ack) begin
                        state         <= VECTOR;
                        cpu_interrupt <= 1'b0;
                        vec_valid     <= 1'b1;
                        active_id     <= win_id;
                        vec_addr      <= win_vec;
                    end
                end
                VECTOR: begin
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (eoi)
                        state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    cpu_interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed vector table, reset corner sequence, then
// random stimulus against a cycle-level behavioural model.
module tb_int_controller;

    localparam int BASE_A = 'h0010;
    localparam int BASE_W = 'hFFF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_src, cfg_data;
    logic        cfg_write, mask_all, unmask_all, int_ack, eoi;

    logic        ci_a, vv_a, ci_w, vv_w;
    logic [15:0] va_a, va_w;
    logic [3:0]  aid_a, aid_w;
    logic [7:0]  pend_a, pend_w;

    int n_checks = 0;
    int n_pass   = 0;

    int_controller #(.N_SRC(8), .VEC_BASE(16'h0010), .VEC_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .cfg_write(cfg_write),
        .cfg_data(cfg_data), .mask_all(mask_all), .unmask_all(unmask_all),
        .int_ack(int_ack), .eoi(eoi), .cpu_interrupt(ci_a), .vec_valid(vv_a),
        .vec_addr(va_a), .active_id(aid_a), .pending(pend_a)
    );

    int_controller #(.N_SRC(8), .VEC_BASE(16'hFFF0), .VEC_SHIFT(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .cfg_write(cfg_write),
        .cfg_data(cfg_data), .mask_all(mask_all), .unmask_all(unmask_all),
        .int_ack(int_ack), .eoi(eoi), .cpu_interrupt(ci_w), .vec_valid(vv_w),
        .vec_addr(va_w), .active_id(aid_w), .pending(pend_w)
    );

    always #5 clk = ~clk;

    // Behavioural model: the phase is read off the visible outputs
    // (requesting = cpu_interrupt, vectoring = vec_valid) plus an in-service flag.
    logic [7:0]  m_prev, m_pend, m_en;
    logic        m_gie, m_ci, m_vv, m_serv;
    logic [15:0] m_va, m_vaw;
    logic [3:0]  m_aid;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_en = '0; m_gie = 1'b0;
        m_ci = 1'b0; m_vv = 1'b0; m_serv = 1'b0;
        m_va = '0; m_vaw = '0; m_aid = '0;
    endtask

    task automatic model_step();
        logic [7:0] elig, clr;
        int win;
        elig = m_gie ? (m_pend & m_en) : 8'h00;
        win  = -1;
        for (int i = 7; i >= 0; i--)
            if (elig[i]) win = i;
        clr = 8'h00;
        if (m_vv) begin
            m_vv   = 1'b0;
            m_serv = 1'b1;
        end else if (m_serv) begin
            if (eoi) m_serv = 1'b0;
        end else if (m_ci) begin
            if (win < 0) begin
                m_ci = 1'b0;
            end else if (int_ack) begin
                m_ci   = 1'b0;
                m_vv   = 1'b1;
                m_aid  = 4'(win);
                m_va   = 16'((BASE_A + win * 4) % 65536);
                m_vaw  = 16'((BASE_W + win * 4) % 65536);
                clr[win] = 1'b1;
            end
        end else if (win >= 0) begin
            m_ci = 1'b1;
        end
        m_pend = (m_pend & ~clr) | (irq_src & ~m_prev);
        m_prev = irq_src;
        if (cfg_write) m_en = cfg_data;
        if (mask_all) m_gie = 1'b0;
        else if (unmask_all) m_gie = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_model();
        check("m_ci",   32'(ci_a),   32'(m_ci));
        check("m_vv",   32'(vv_a),   32'(m_vv));
        check("m_va",   32'(va_a),   32'(m_va));
        check("m_aid",  32'(aid_a),  32'(m_aid));
        check("m_pend", 32'(pend_a), 32'(m_pend));
        check("m_ci_w", 32'(ci_w),   32'(m_ci));
        check("m_va_w", 32'(va_w),   32'(m_vaw));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        irq_src = '0; cfg_write = 0; cfg_data = '0;
        mask_all = 0; unmask_all = 0; int_ack = 0; eoi = 0;
    endtask

    typedef struct {
        logic [7:0]  irq;
        logic        cw;
        logic [7:0]  cd;
        logic        mk, um, ack, eo;
        logic        ci, vv;
        logic [15:0] va, vaw;
        logic [3:0]  aid;
        logic [7:0]  pend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] irq, input logic cw, input logic [7:0] cd,
                       input logic mk, input logic um, input logic ack, input logic eo,
                       input logic ci, input logic vv, input logic [15:0] va,
                       input logic [15:0] vaw, input logic [3:0] aid, input logic [7:0] pend);
        vec_t v;
        v.irq = irq; v.cw = cw; v.cd = cd; v.mk = mk; v.um = um; v.ack = ack; v.eo = eo;
        v.ci = ci; v.vv = vv; v.va = va; v.vaw = vaw; v.aid = aid; v.pend = pend;
        tbl.push_back(v);
    endtask

    initial begin
        // irq cw cd mk um ack eoi | ci vv va vaw aid pend
        add(8'h00,1,8'hFF,0,1,0,0, 0,0,16'h0000,16'h0000,0,8'h00);
        add(8'h08,0,8'h00,0,0,0,0, 0,0,16'h0000,16'h0000,0,8'h08);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0000,16'h0000,0,8'h08);
        add(8'h00,0,8'h00,0,0,1,0, 0,1,16'h001C,16'hFFFC,3,8'h00);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h001C,16'hFFFC,3,8'h00);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h001C,16'hFFFC,3,8'h00);
        add(8'h22,0,8'h00,0,0,0,0, 0,0,16'h001C,16'hFFFC,3,8'h22);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h001C,16'hFFFC,3,8'h22);
        add(8'h00,0,8'h00,0,0,1,0, 0,1,16'h0014,16'hFFF4,1,8'h20);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0014,16'hFFF4,1,8'h20);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0014,16'hFFF4,1,8'h20);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0014,16'hFFF4,1,8'h20);
        add(8'h00,0,8'h00,0,0,1,0, 0,1,16'h0024,16'h0004,5,8'h00);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0024,16'h0004,5,8'h00);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0024,16'h0004,5,8'h00);
        add(8'h10,0,8'h00,0,0,0,0, 0,0,16'h0024,16'h0004,5,8'h10);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0024,16'h0004,5,8'h10);
        add(8'h01,0,8'h00,0,0,0,0, 1,0,16'h0024,16'h0004,5,8'h11);
        add(8'h00,0,8'h00,0,0,1,0, 0,1,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,1,0,0,0, 1,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,1,0,0, 0,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,1,1,0,0, 1,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,1,0,0, 0,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0010,16'hFFF0,0,8'h10);
        add(8'h00,0,8'h00,0,0,1,0, 0,1,16'h0020,16'h0000,4,8'h00);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0020,16'h0000,4,8'h00);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0020,16'h0000,4,8'h00);
        add(8'h00,1,8'hFB,0,0,0,0, 0,0,16'h0020,16'h0000,4,8'h00);
        add(8'h04,0,8'h00,0,0,0,0, 0,0,16'h0020,16'h0000,4,8'h04);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0020,16'h0000,4,8'h04);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0020,16'h0000,4,8'h04);
        add(8'h00,1,8'hFF,0,0,0,0, 0,0,16'h0020,16'h0000,4,8'h04);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0020,16'h0000,4,8'h04);
        add(8'h00,0,8'h00,0,0,1,0, 0,1,16'h0018,16'hFFF8,2,8'h00);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0018,16'hFFF8,2,8'h00);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0018,16'hFFF8,2,8'h00);
        add(8'h00,0,8'h00,0,0,1,0, 0,0,16'h0018,16'hFFF8,2,8'h00);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0018,16'hFFF8,2,8'h00);
        add(8'h40,0,8'h00,0,0,0,0, 0,0,16'h0018,16'hFFF8,2,8'h40);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0018,16'hFFF8,2,8'h40);
        add(8'h40,0,8'h00,0,0,1,0, 0,1,16'h0028,16'h0008,6,8'h40);
        add(8'h00,0,8'h00,0,0,1,0, 0,0,16'h0028,16'h0008,6,8'h40);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0028,16'h0008,6,8'h40);
        add(8'h00,0,8'h00,0,0,0,0, 1,0,16'h0028,16'h0008,6,8'h40);
        add(8'h00,0,8'h00,0,0,1,0, 0,1,16'h0028,16'h0008,6,8'h00);
        add(8'h00,0,8'h00,0,0,0,0, 0,0,16'h0028,16'h0008,6,8'h00);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h0028,16'h0008,6,8'h00);
        add(8'h80,0,8'h00,0,0,0,0, 0,0,16'h0028,16'h0008,6,8'h80);
        add(8'h80,0,8'h00,0,0,0,0, 1,0,16'h0028,16'h0008,6,8'h80);
        add(8'h80,0,8'h00,0,0,1,0, 0,1,16'h002C,16'h000C,7,8'h00);
        add(8'h80,0,8'h00,0,0,0,0, 0,0,16'h002C,16'h000C,7,8'h00);
        add(8'h00,0,8'h00,0,0,0,1, 0,0,16'h002C,16'h000C,7,8'h00);

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        check("rst_ci",   32'(ci_a),   0);
        check("rst_vv",   32'(vv_a),   0);
        check("rst_va",   32'(va_a),   0);
        check("rst_aid",  32'(aid_a),  0);
        check("rst_pend", 32'(pend_a), 0);
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            irq_src = tbl[r].irq; cfg_write = tbl[r].cw; cfg_data = tbl[r].cd;
            mask_all = tbl[r].mk; unmask_all = tbl[r].um; int_ack = tbl[r].ack; eoi = tbl[r].eo;
            cycle();
            check($sformatf("row%0d_ci", r),   32'(ci_a),   32'(tbl[r].ci));
            check($sformatf("row%0d_vv", r),   32'(vv_a),   32'(tbl[r].vv));
            check($sformatf("row%0d_va", r),   32'(va_a),   32'(tbl[r].va));
            check($sformatf("row%0d_vaw", r),  32'(va_w),   32'(tbl[r].vaw));
            check($sformatf("row%0d_aid", r),  32'(aid_a),  32'(tbl[r].aid));
            check($sformatf("row%0d_pend", r), 32'(pend_a), 32'(tbl[r].pend));
        end

        // Reset during SERVICE with source 1 held high throughout.
        idle_inputs();
        irq_src = 8'h02;
        cycle();
        cycle();
        check("svc_req", 32'(ci_a), 1);
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("arst_ci",   32'(ci_a),   0);
        check("arst_vv",   32'(vv_a),   0);
        check("arst_va",   32'(va_a),   0);
        check("arst_aid",  32'(aid_a),  0);
        check("arst_pend", 32'(pend_a), 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("held_pend1", 32'(pend_a), 32'h02);
        cycle();
        check("held_ci_dis", 32'(ci_a), 0);
        cfg_write = 1'b1; cfg_data = 8'hFF; unmask_all = 1'b1;
        cycle();
        cfg_write = 1'b0; unmask_all = 1'b0;
        cycle();
        check("held_req", 32'(ci_a), 1);
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;
        check("held_aid", 32'(aid_a), 1);
        check("held_clr", 32'(pend_a), 0);
        cycle();
        check("held_once", 32'(pend_a), 0);
        eoi = 1'b1;
        cycle();
        eoi = 1'b0;
        cycle();
        check("held_noreq", 32'(ci_a), 0);

        // Randomised phase against the model.
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            irq_src    = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            cfg_write  = ($urandom_range(0, 31) == 0);
            cfg_data   = 8'($urandom) | 8'($urandom);
            mask_all   = ($urandom_range(0, 39) == 0);
            unmask_all = ($urandom_range(0, 7) == 0);
            int_ack    = ($urandom_range(0, 2) == 0);
            eoi        = ($urandom_range(0, 3) == 0);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                compare_model();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
